// File: rtl/neopixel_tx.sv
// -----------------------------------------------------------------------------
// neopixel_tx
//
// WS2812 / NeoPixel single-wire serializer. Takes one pixel per valid/busy
// handshake, shifts it out MSB-first as timed high/low pulses on one pin and
// flags when the line has been low long enough for the strip to latch.
// All timings are whole CLK cycles.
//
// Build option:
//   NEOPIXEL_RGBW_EN  defined   -> extra i_w port, 32-bit {G,R,B,W} frame
//                     undefined -> 24-bit {G,R,B} frame (default)
//
// Parameters:
//   BIT_CYC    cycles per bit period            (must be > T1H_CYC)
//   T0H_CYC    high cycles for a '0' bit        (must be >= 1)
//   T1H_CYC    high cycles for a '1' bit        (must be > T0H_CYC)
//   RESET_CYC  low cycles that latch the strip
//
// Ports:
//   CLK        in   system clock
//   RST        in   asynchronous reset, active-high
//   i_valid    in   pixel offered (level, held until o_busy is seen high)
//   i_r/g/b    in   8-bit colour channels
//   i_w        in   8-bit white channel (NEOPIXEL_RGBW_EN only)
//   o_data     out  serial line to strip DIN
//   o_busy     out  high while a pixel is being shifted out
//   o_latched  out  high once the line has been low >= RESET_CYC cycles
// -----------------------------------------------------------------------------
module neopixel_tx #(
    parameter int unsigned BIT_CYC   = 15,
    parameter int unsigned T0H_CYC   = 4,
    parameter int unsigned T1H_CYC   = 9,
    parameter int unsigned RESET_CYC = 960
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_valid,
    input  logic [7:0] i_r,
    input  logic [7:0] i_g,
    input  logic [7:0] i_b,
`ifdef NEOPIXEL_RGBW_EN
    input  logic [7:0] i_w,
`endif
    output logic       o_data,
    output logic       o_busy,
    output logic       o_latched
);

`ifdef NEOPIXEL_RGBW_EN
    localparam int unsigned FRAME_BITS = 32;
`else
    localparam int unsigned FRAME_BITS = 24;
`endif

    localparam int unsigned BIDX_W = $clog2(FRAME_BITS);
    localparam int unsigned CYC_W  = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int unsigned LOW_W  = $clog2(RESET_CYC + 1);

    localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0]  T0H_C    = CYC_W'(T0H_CYC);
    localparam logic [CYC_W-1:0]  T1H_C    = CYC_W'(T1H_CYC);
    localparam logic [BIDX_W-1:0] BIT_LAST = BIDX_W'(FRAME_BITS - 1);
    localparam logic [LOW_W-1:0]  LOW_MAX  = LOW_W'(RESET_CYC);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e                  state_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [BIDX_W-1:0]       bit_q;
    logic [CYC_W-1:0]        cyc_q;
    logic [LOW_W-1:0]        low_cnt_q;
    logic                    data_q;
    logic                    busy_q;
    logic                    latched_q;

    logic [FRAME_BITS-1:0]   frame_in;
    logic                    accept;
    logic [CYC_W-1:0]        cyc_nxt;
    logic [CYC_W-1:0]        hi_thr;
    logic [LOW_W-1:0]        low_cnt_d;

    // Green goes out first, so it sits in the MSBs of the shift register.
`ifdef NEOPIXEL_RGBW_EN
    assign frame_in = {i_g, i_r, i_b, i_w};
`else
    assign frame_in = {i_g, i_r, i_b};
`endif

    // busy_q is exactly "state is SHIFT", so valid during busy is ignored.
    assign accept = i_valid && !busy_q;

    always_comb begin
        // NOTE: every signal gets a value before any branch so no latch is inferred.
        cyc_nxt   = cyc_q + CYC_W'(1);
        hi_thr    = shift_q[FRAME_BITS-1] ? T1H_C : T0H_C;
        low_cnt_d = low_cnt_q;
        // Saturate so the low-time counter can never wrap back below RESET_CYC.
        if (low_cnt_q != LOW_MAX) begin
            low_cnt_d = low_cnt_q + LOW_W'(1);
        end
    end

    // All outputs are registered: each branch computes what the line shows
    // during the cycle that follows the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the shift register is reset too; it is small flops, not a memory.
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            cyc_q     <= '0;
            low_cnt_q <= '0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
            latched_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state_q)
                IDLE: begin
                    data_q <= 1'b0;
                    if (accept) begin
                        // Accept beats a latch that would otherwise rise on this edge.
                        state_q   <= SHIFT;
                        shift_q   <= frame_in;
                        bit_q     <= '0;
                        cyc_q     <= '0;
                        busy_q    <= 1'b1;
                        low_cnt_q <= '0;
                        latched_q <= 1'b0;
                        // Cycle 0 of any bit is high because T0H_CYC >= 1.
                        data_q    <= 1'b1;
                    end else begin
                        low_cnt_q <= low_cnt_d;
                        latched_q <= (low_cnt_d == LOW_MAX);
                    end
                end

                SHIFT: begin
                    if (cyc_q == CYC_LAST) begin
                        cyc_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            // Last bit period ends: line rests low, counting starts next cycle.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            data_q  <= 1'b0;
                        end else begin
                            bit_q   <= bit_q + BIDX_W'(1);
                            shift_q <= shift_q << 1;
                            data_q  <= 1'b1;
                        end
                    end else begin
                        cyc_q  <= cyc_nxt;
                        data_q <= (cyc_nxt < hi_thr);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    data_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data    = data_q;
    assign o_busy    = busy_q;
    assign o_latched = latched_q;

endmodule
